m_mem_arb: RTL and testbench
============================

# m_mem_arb

Two-requester arbiter that shares the single-port synchronous instruction/data memory (one-cycle read latency, 64 words) between the fetch stage and the load/store stage of the CPU. Each cycle it grants at most one requester, drives the memory port, and returns read data to the owner one cycle later. Data accesses win by default; a starvation guard bounds how long fetch can be locked out.

## Interface
- DATA_W, 32, data and address width
- DEPTH_LOG2, 6, memory word-index width (64 words)
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win (guard build only)

- w_clk  input  1  clock, rising edge
- w_rst_n  input  1  asynchronous, active-low reset
- w_if_req  input  1  fetch read request
- w_if_addr  input  DATA_W  fetch byte address
- w_if_gnt  output  1  fetch granted this cycle
- w_if_rvalid  output  1  fetch read data valid
- w_if_rdata  output  DATA_W  fetch read data
- w_d_req  input  1  data request
- w_d_we  input  1  1 = write, 0 = read
- w_d_addr  input  DATA_W  data byte address
- w_d_wdata  input  DATA_W  write data
- w_d_gnt  output  1  data granted this cycle
- w_d_rvalid  output  1  data read data valid
- w_d_rdata  output  DATA_W  data read data
- w_mem_en  output  1  memory access this cycle
- w_mem_we  output  1  memory write strobe
- w_mem_addr  output  DEPTH_LOG2  word index
- w_mem_wdata  output  DATA_W  memory write data
- w_mem_rdata  input  DATA_W  memory read data, valid one cycle after a read enable

## Operation
- Handshake: a transfer happens at a rising edge where req and gnt are both 1. Requesters hold req, addr, we and wdata stable until granted. gnt is combinational from req and state.
- Grants are one-hot or zero. With the guard inactive, w_d_req wins; fetch is granted only when w_d_req = 0.
- Memory port: w_mem_en = w_if_gnt | w_d_gnt; w_mem_we = w_d_gnt & w_d_we. w_mem_addr = granted addr[DEPTH_LOG2+1:2], so bits [1:0] are ignored. w_mem_wdata = w_d_wdata.
- Owner register: holds NONE, IF or D. It loads the granted reader on each granted read; writes and idle cycles load NONE.
- Responses: when owner = IF, w_if_rvalid = 1. When owner = D, w_d_rvalid = 1. Both rdata outputs pass w_mem_rdata through and are don't-care when their rvalid is 0.
- Writes return no rvalid.
- Back-to-back granted reads give rvalid on consecutive cycles, so throughput is one access per cycle.

## Timing
- Read latency: rvalid occurs exactly 1 cycle after the granting edge.
- Grant latency: 0 cycles when uncontended.
- Reset (w_rst_n = 0): owner = NONE, starvation counter = 0, both rvalid = 0. Both gnt = 0 and w_mem_en = w_mem_we = 0 regardless of req. w_mem_addr and w_mem_wdata read as 0.
- Reset asserted while a read is in flight: the read is dropped, and no rvalid appears after release.
- First grant is possible in the first cycle after w_rst_n rises.
- Simultaneous requests: resolved by the priority rules in the Operation and Configuration sections. Exactly one requester is granted.
- Address wrap: addresses at or above 4·2^DEPTH_LOG2 alias modulo 64 words.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A saturating counter r_if_wait (width clog2(MAX_WAIT+1)) increments on each cycle with w_if_req & ~w_if_gnt.
  - It clears when fetch is granted or when w_if_req = 0.
  - When r_if_wait = MAX_WAIT, fetch has priority over data for that cycle.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data priority. No counter is built, and fetch can starve indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - the owner enum (OWN_NONE, OWN_IF, OWN_D)
  - DATA_W and DEPTH_LOG2 defaults
  - the helper that extracts the word index
- Sub-module m_arb_pick2 is a combinational two-input priority picker. Inputs: two reqs and a "swap priority" bit. Outputs: one-hot grants. The guard drives the swap bit.
- m_mem_arb holds the owner register, the counter, and the port muxing.

## Test plan
- Reset then a lone fetch read of addr 0x8, with mem[2] = 2: w_if_gnt = 1 in the same cycle; the next cycle gives w_if_rvalid = 1 and rdata = 2; w_d_rvalid stays 0.
- Fetch and data read both requesting, data addr 0xC with mem[3] = 4: w_d_gnt = 1 and w_if_gnt = 0; the next cycle gives w_d_rvalid = 1 and rdata = 4; fetch is granted on the following cycle.
- Data write of 0xDEADBEEF to addr 0x10, then a data read of 0x10: the write cycle has w_mem_we = 1 and w_mem_addr = 4, with no rvalid; the read returns 0xDEADBEEF.
- Guard build with MAX_WAIT = 4 and both requests held high:
  - data is granted for 4 cycles, then fetch for 1, then the pattern repeats;
  - without the macro, fetch is never granted.
- Read granted, then w_rst_n pulsed low for one half-cycle before the next edge: no rvalid after release, and all outputs return to 0 during reset.
- Fetch addr 0x104: w_mem_addr = 1, because of the modulo-64 alias.

Source files
------------

// File: rtl/m_mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Owner encoding, default widths and the byte-to-word index helper.
package mem_arb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_LOG2_DEF = 6;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } own_e;

    // Byte address to word index; low two bits and high bits drop out
    function automatic logic [DEPTH_LOG2_DEF-1:0] word_idx(
        input logic [DATA_W_DEF-1:0] addr
    );
        return addr[DEPTH_LOG2_DEF+1:2];
    endfunction

endpackage

// File: rtl/m_mem_arb_if.sv
// Bundle between the two requesters, the arbiter and the memory port.
// master = requesters plus memory model, slave = arbiter.
interface m_mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
    logic                  w_if_req;
    logic [DATA_W-1:0]     w_if_addr;
    logic                  w_if_gnt;
    logic                  w_if_rvalid;
    logic [DATA_W-1:0]     w_if_rdata;

    logic                  w_d_req;
    logic                  w_d_we;
    logic [DATA_W-1:0]     w_d_addr;
    logic [DATA_W-1:0]     w_d_wdata;
    logic                  w_d_gnt;
    logic                  w_d_rvalid;
    logic [DATA_W-1:0]     w_d_rdata;

    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic [DATA_W-1:0]     w_mem_rdata;

    modport master (
        output w_if_req, w_if_addr,
        output w_d_req, w_d_we, w_d_addr, w_d_wdata,
        output w_mem_rdata,
        input  w_if_gnt, w_if_rvalid, w_if_rdata,
        input  w_d_gnt, w_d_rvalid, w_d_rdata,
        input  w_mem_en, w_mem_we, w_mem_addr, w_mem_wdata
    );

    modport slave (
        input  w_if_req, w_if_addr,
        input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
        input  w_mem_rdata,
        output w_if_gnt, w_if_rvalid, w_if_rdata,
        output w_d_gnt, w_d_rvalid, w_d_rdata,
        output w_mem_en, w_mem_we, w_mem_addr, w_mem_wdata
    );

endinterface

// File: rtl/m_arb_pick2.sv
// Two-input combinational priority picker with one-hot grants.
// Input a wins by default; w_swap hands priority to input b.
module m_arb_pick2 (
    input  logic w_req_a,
    input  logic w_req_b,
    input  logic w_swap,
    output logic w_gnt_a,
    output logic w_gnt_b
);

    // Loser yields only when the winner is actually requesting
    always_comb begin
        w_gnt_a = w_req_a & ~(w_swap & w_req_b);
        w_gnt_b = w_req_b & ~(~w_swap & w_req_a);
    end

endmodule

// File: rtl/m_mem_arb.sv
// Fetch vs load/store arbiter for the shared one-cycle-latency memory.
// MEM_ARB_STARVE_GUARD_EN builds a counter that bounds fetch lockout.
module m_mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT   = 4
`endif
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_mem_arb_if.slave  bus
);

    logic w_d_pick;
    logic w_if_pick;
    logic w_swap;
    own_e r_own;
    own_e w_own_nxt;

    // Requests are masked in reset so no grant or strobe leaks out
    m_arb_pick2 u_pick (
        .w_req_a (bus.w_d_req & w_rst_n),
        .w_req_b (bus.w_if_req & w_rst_n),
        .w_swap  (w_swap),
        .w_gnt_a (w_d_pick),
        .w_gnt_b (w_if_pick)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_if_wait;

    // Count consecutive denied fetch cycles, saturating at the limit
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_if_wait <= '0;
        else if (!bus.w_if_req || w_if_pick)
            r_if_wait <= '0;
        else if (r_if_wait != WAIT_MAX)
            r_if_wait <= r_if_wait + 1'b1;
    end

    assign w_swap = (r_if_wait == WAIT_MAX);
`else
    assign w_swap = 1'b0;
`endif

    // Owner of the read now in flight
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_own <= OWN_NONE;
        else
            r_own <= w_own_nxt;
    end

    // Only granted reads claim the return slot
    always_comb begin
        w_own_nxt = OWN_NONE;
        unique case (1'b1)
            w_d_pick & ~bus.w_d_we: w_own_nxt = OWN_D;
            w_if_pick:              w_own_nxt = OWN_IF;
            default:                w_own_nxt = OWN_NONE;
        endcase
    end

    // Memory port follows the granted requester, zero when idle
    always_comb begin
        bus.w_mem_addr = '0;
        if (w_d_pick)
            bus.w_mem_addr = word_idx(bus.w_d_addr);
        else if (w_if_pick)
            bus.w_mem_addr = word_idx(bus.w_if_addr);
    end

    assign bus.w_if_gnt    = w_if_pick;
    assign bus.w_d_gnt     = w_d_pick;
    assign bus.w_mem_en    = w_if_pick | w_d_pick;
    assign bus.w_mem_we    = w_d_pick & bus.w_d_we;
    assign bus.w_mem_wdata = w_rst_n ? bus.w_d_wdata : '0;

    assign bus.w_if_rvalid = (r_own == OWN_IF);
    assign bus.w_d_rvalid  = (r_own == OWN_D);
    assign bus.w_if_rdata  = bus.w_mem_rdata;
    assign bus.w_d_rdata   = bus.w_mem_rdata;

endmodule

// File: tb/tb_m_mem_arb.sv
// Scoreboard bench for m_mem_arb: directed stimulus queues responses,
// a negedge monitor matches every rvalid against the queue.
module tb_m_mem_arb;

    logic w_clk = 1'b0;
    logic w_rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [31:0] mem [64];
    bit          wr_ok [64];

    m_mem_arb_if bus ();

    m_mem_arb dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) cyc <= cyc + 1;

    // Hand-chosen power-up contents of the memory model
    function automatic logic [31:0] init_val(input logic [5:0] a);
        case (a)
            6'd1:    return 32'h0000_0011;
            6'd2:    return 32'h0000_0002;
            6'd3:    return 32'h0000_0004;
            6'd4:    return 32'h0000_0044;
            default: return 32'h0000_1000 + 32'(a);
        endcase
    endfunction

    // Single-port synchronous memory, one-cycle read latency
    always @(posedge w_clk) begin
        if (bus.w_mem_en) begin
            if (bus.w_mem_we) begin
                mem[bus.w_mem_addr]   <= bus.w_mem_wdata;
                wr_ok[bus.w_mem_addr] <= 1'b1;
            end else begin
                bus.w_mem_rdata <= wr_ok[bus.w_mem_addr]
                    ? mem[bus.w_mem_addr]
                    : init_val(bus.w_mem_addr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest queued response
    always @(negedge w_clk) begin
        if (bus.w_if_rvalid || bus.w_d_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rvalid",
                    {30'd0, bus.w_if_rvalid, bus.w_d_rvalid}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_who",
                    {30'd0, bus.w_if_rvalid, bus.w_d_rvalid},
                    e.is_if ? 32'd2 : 32'd1);
                chk("rdata",
                    e.is_if ? bus.w_if_rdata : bus.w_d_rdata, e.data);
                chk("rvalid_cycle", cyc, e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_rvalid", 0, 1);
        end
    end

    task automatic drv(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
        bus.w_if_req   = ir;
        bus.w_if_addr  = ia;
        bus.w_d_req    = dr;
        bus.w_d_we     = dw;
        bus.w_d_addr   = da;
        bus.w_d_wdata  = dd;
    endtask

    // Check one cycle's grants and port; queue the expected read data
    task automatic issue(input string nm, input logic eif,
                         input logic ed, input logic [31:0] erd,
                         input logic [5:0] eaddr);
        @(negedge w_clk);
        #1;
        chk({nm, ".if_gnt"}, bus.w_if_gnt, eif);
        chk({nm, ".d_gnt"}, bus.w_d_gnt, ed);
        chk({nm, ".mem_en"}, bus.w_mem_en, eif | ed);
        chk({nm, ".mem_we"}, bus.w_mem_we, ed & bus.w_d_we);
        chk({nm, ".mem_addr"}, bus.w_mem_addr, eaddr);
        if (eif || (ed && !bus.w_d_we))
            exp_q.push_back('{eif, erd, cyc + 1});
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".if_gnt"}, bus.w_if_gnt, 0);
        chk({nm, ".d_gnt"}, bus.w_d_gnt, 0);
        chk({nm, ".mem_en"}, bus.w_mem_en, 0);
        chk({nm, ".mem_we"}, bus.w_mem_we, 0);
        chk({nm, ".mem_addr"}, bus.w_mem_addr, 0);
        chk({nm, ".mem_wdata"}, bus.w_mem_wdata, 0);
        chk({nm, ".if_rvalid"}, bus.w_if_rvalid, 0);
        chk({nm, ".d_rvalid"}, bus.w_d_rvalid, 0);
    endtask

    initial begin
        logic eif;
        bus.w_mem_rdata = '0;
        drv(1, 32'h8, 1, 1, 32'h10, 32'h55);
        #2;
        chk_reset_outs("reset");
        #10;
        drv(0, 0, 0, 0, 0, 0);
        w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;

        drv(1, 32'h8, 0, 0, 0, 0);
        issue("lone_fetch", 1, 0, 32'h2, 6'd2);

        drv(1, 32'h8, 1, 0, 32'hC, 0);
        issue("contend", 0, 1, 32'h4, 6'd3);
        drv(1, 32'h8, 0, 0, 0, 0);
        issue("fetch_after", 1, 0, 32'h2, 6'd2);

        drv(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        issue("write", 0, 1, 0, 6'd4);
        drv(0, 0, 1, 0, 32'h10, 0);
        issue("read_back", 0, 1, 32'hDEAD_BEEF, 6'd4);

        drv(1, 32'h104, 0, 0, 0, 0);
        issue("alias", 1, 0, 32'h11, 6'd1);

        drv(0, 0, 0, 0, 0, 0);
        issue("idle", 0, 0, 0, 6'd0);

        drv(1, 32'h8, 1, 0, 32'hC, 0);
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            eif = (i % 5 == 4);
`else
            eif = 1'b0;
`endif
            issue("guard", eif, !eif, eif ? 32'h2 : 32'h4,
                  eif ? 6'd2 : 6'd3);
        end

        drv(0, 0, 0, 0, 0, 0);
        issue("idle2", 0, 0, 0, 6'd0);
        issue("idle3", 0, 0, 0, 6'd0);

        drv(1, 32'h8, 0, 0, 0, 0);
        @(negedge w_clk);
        #1;
        chk("inflight.if_gnt", bus.w_if_gnt, 1);
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b0;
        drv(1, 32'h8, 1, 1, 32'h10, 32'h77);
        #1;
        chk_reset_outs("inflight_rst");
        #2;
        drv(0, 0, 0, 0, 0, 0);
        w_rst_n = 1'b1;
        issue("post_rst", 0, 0, 0, 6'd0);
        issue("post_rst", 0, 0, 0, 6'd0);
        issue("post_rst", 0, 0, 0, 6'd0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
